// File: rtl/shift_pkg.sv
// Shared opcodes and level-to-stage mapping for the pipelined barrel shifter.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Pipeline stage that owns shift level k (levels run from the MSB of shamt down).
    function automatic int level_stage(input int k, input int shamt_w, input int pipe_stages);
        return ((shamt_w - 1 - k) * pipe_stages) / shamt_w;
    endfunction

    // Highest level owned by stage s.
    function automatic int stage_k_hi(input int s, input int shamt_w, input int pipe_stages);
        int r;
        r = 0;
        for (int k = 0; k < shamt_w; k++) begin
            if (level_stage(k, shamt_w, pipe_stages) == s) r = k;
        end
        return r;
    endfunction

    // Lowest level owned by stage s.
    function automatic int stage_k_lo(input int s, input int shamt_w, input int pipe_stages);
        int r;
        r = 0;
        for (int k = shamt_w - 1; k >= 0; k--) begin
            if (level_stage(k, shamt_w, pipe_stages) == s) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: shift levels [K_HI:K_LO] followed by a valid/ready register.
module shifter_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5,
    parameter int          K_HI    = 4,
    parameter int          K_LO    = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    input  logic               sign_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [1:0]         op_o,
    output logic               sign_o,
    output logic [TAG_W-1:0]   tag_o
);

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   shifted;
    logic               advance;

    // Single shift level by amt; SRA fill uses the sign captured at accept.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [1:0] op,
                                                     input logic sign,
                                                     input int unsigned amt);
        logic [WIDTH-1:0] res;
        case (op)
            OP_SLL:  res = d << amt;
            OP_SRL:  res = d >> amt;
            OP_SRA:  res = (d >> amt) | ({WIDTH{sign}} << (WIDTH - amt));
            default: res = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return res;
    endfunction

    // Apply this stage's levels, most significant first.
    always_comb begin
        shifted = data_i;
        for (int k = K_HI; k >= K_LO; k--) begin
            if (shamt_i[k]) shifted = shift_level(shifted, op_i, sign_i, 1 << k);
        end
    end

    assign advance = !valid_q || ready_i;
    assign ready_o = advance && !flush_i;

    // Next-state: flush kills the stage, otherwise load whenever the register can move.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        tag_d   = tag_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d  = shifted;
                shamt_d = shamt_i;
                op_d    = op_i;
                sign_d  = sign_i;
                tag_d   = tag_i;
            end
        end
    end

    // Stage register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign sign_o  = sign_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready on both sides and a tag sideband.
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SHAMT_W     = $clog2(WIDTH),
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    if (PIPE_STAGES == 0 || PIPE_STAGES > SHAMT_W) begin : g_bad_pipe
        $error("PIPE_STAGES must be in 1..SHAMT_W");
    end
    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("WIDTH must be a power of 2 and >= 8");
    end
    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
        $error("SHAMT_W is derived from WIDTH and must not be overridden");
    end

    // Index s is the input of stage s; index PIPE_STAGES is the output port.
    logic [PIPE_STAGES:0] vld;
    logic [PIPE_STAGES:0] rdy;
    logic [WIDTH-1:0]     dat [PIPE_STAGES+1];
    logic [SHAMT_W-1:0]   shm [PIPE_STAGES+1];
    logic [1:0]           opc [PIPE_STAGES+1];
    logic                 sgn [PIPE_STAGES+1];
    logic [TAG_W-1:0]     tag [PIPE_STAGES+1];

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign shm[0] = in_shamt;
    assign opc[0] = in_op;
    assign sgn[0] = in_data[WIDTH-1];
    assign tag[0] = in_tag;
    assign in_ready = rdy[0];

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int KHi = stage_k_hi(s, int'(SHAMT_W), int'(PIPE_STAGES));
        localparam int KLo = stage_k_lo(s, int'(SHAMT_W), int'(PIPE_STAGES));

        shifter_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .K_HI    (KHi),
            .K_LO    (KLo)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .flush_i (flush),
            .valid_i (vld[s]),
            .ready_o (rdy[s]),
            .data_i  (dat[s]),
            .shamt_i (shm[s]),
            .op_i    (opc[s]),
            .sign_i  (sgn[s]),
            .tag_i   (tag[s]),
            .valid_o (vld[s+1]),
            .ready_i (rdy[s+1]),
            .data_o  (dat[s+1]),
            .shamt_o (shm[s+1]),
            .op_o    (opc[s+1]),
            .sign_o  (sgn[s+1]),
            .tag_o   (tag[s+1])
        );
    end

    assign rdy[PIPE_STAGES] = out_ready;
    assign out_valid        = vld[PIPE_STAGES];
    assign out_data         = dat[PIPE_STAGES];
    assign out_tag          = tag[PIPE_STAGES];

    // Control fields are spent once the last level has been applied.
    logic unused_tail;
    assign unused_tail = ^{shm[PIPE_STAGES], opc[PIPE_STAGES], sgn[PIPE_STAGES]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench: one directed PIPE_STAGES=2 instance plus random instances for PIPE_STAGES=1..5,
// each scored against a queue-based reference model.
module tb_pipelined_barrel_shifter;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int unsigned t;
    } exp_t;

    logic clk;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic [1:0] op);
        logic [63:0] dd;
        case (op)
            SLL:     return d << sh;
            SRL:     return d >> sh;
            SRA:     return 32'($signed(d) >>> sh);
            default: begin
                dd = {d, d} >> sh;
                return dd[31:0];
            end
        endcase
    endfunction

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s (inst %0d) at %0t: got 0x%08h, expected 0x%08h",
                     nm, inst, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi <= 5; gi++) begin : g_inst
        localparam int unsigned P = (gi == 0) ? 2 : gi;

        logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
        logic [31:0] in_data, out_data;
        logic [4:0]  in_shamt, in_tag, out_tag;
        logic [1:0]  in_op;

        pipelined_barrel_shifter #(
            .WIDTH       (32),
            .PIPE_STAGES (P),
            .TAG_W       (5)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_shamt  (in_shamt),
            .in_op     (in_op),
            .in_tag    (in_tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_tag   (out_tag)
        );

        // Reference model: ops in flight in acceptance order, each stamped with its accept cycle.
        initial begin : monitor
            exp_t        q[$];
            int unsigned cyc;
            logic        exp_ov;
            cyc = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                end else begin
                    exp_ov = (q.size() != 0) && (q[0].t + P <= cyc);
                    check("out_valid", gi, {31'b0, out_valid}, {31'b0, exp_ov});
                    if (out_valid && q.size() != 0) begin
                        check("out_data", gi, out_data, q[0].data);
                        check("out_tag", gi, {27'b0, out_tag}, {27'b0, q[0].tag});
                    end
                    check("in_ready", gi, {31'b0, in_ready},
                          {31'b0, !flush && (q.size() < P || out_ready)});
                    if (flush) begin
                        q.delete();
                    end else begin
                        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                        if (in_valid && in_ready)
                            q.push_back('{data: ref_shift(in_data, in_shamt, in_op),
                                          tag: in_tag, t: cyc});
                    end
                end
                cyc++;
            end
        end

        task automatic sync();
            @(posedge clk);
            #1;
        endtask

        task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                             input logic [4:0] sh, input logic [4:0] tg);
            in_valid = v;
            in_op    = op;
            in_data  = d;
            in_shamt = sh;
            in_tag   = tg;
        endtask

        if (gi == 0) begin : g_directed
            // One op through an empty pipe with out_ready=1; result 2 cycles after accept.
            task automatic run_one(input string nm, input logic [1:0] op, input logic [31:0] d,
                                   input logic [4:0] sh, input logic [4:0] tg,
                                   input logic [31:0] exp);
                sync();
                drive(1'b1, op, d, sh, tg);
                #2 check({nm, " accept"}, gi, {31'b0, in_ready}, 32'd1);
                sync();
                in_valid = 1'b0;
                #2 check({nm, " early"}, gi, {31'b0, out_valid}, 32'd0);
                sync();
                #2 check({nm, " valid"}, gi, {31'b0, out_valid}, 32'd1);
                check({nm, " data"}, gi, out_data, exp);
                check({nm, " tag"}, gi, {27'b0, out_tag}, {27'b0, tg});
            endtask

            initial begin
                int acc;
                rst_n = 1'b1;
                flush = 1'b0;
                out_ready = 1'b1;
                drive(1'b0, SLL, 32'd0, 5'd0, 5'd0);
                #1 rst_n = 1'b0;
                #2;
                check("reset out_valid", gi, {31'b0, out_valid}, 32'd0);
                check("reset out_data", gi, out_data, 32'd0);
                check("reset out_tag", gi, {27'b0, out_tag}, 32'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                #2 check("in_ready after reset", gi, {31'b0, in_ready}, 32'd1);

                run_one("sra31", SRA, 32'h8000_0000, 5'd31, 5'd1, 32'hFFFF_FFFF);
                run_one("srl4", SRL, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000);
                run_one("sll31", SLL, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000);
                run_one("ror4", ROR, 32'h0000_00F1, 5'd4, 5'd4, 32'h1000_000F);
                run_one("sra0", SRA, 32'h8123_4567, 5'd0, 5'd5, 32'h8123_4567);
                run_one("ror0", ROR, 32'hDEAD_BEEF, 5'd0, 5'd6, 32'hDEAD_BEEF);

                // Eight back-to-back ops, results on eight consecutive cycles.
                sync();
                for (int k = 0; k <= 10; k++) begin
                    drive(k < 8, SLL, 32'd1, 5'(k), 5'(k));
                    #2;
                    if (k >= 2 && k < 10) begin
                        check("b2b valid", gi, {31'b0, out_valid}, 32'd1);
                        check("b2b tag", gi, {27'b0, out_tag}, k - 2);
                        check("b2b data", gi, out_data, 32'd1 << (k - 2));
                    end else if (k == 10) begin
                        check("b2b done", gi, {31'b0, out_valid}, 32'd0);
                    end
                    sync();
                end

                // Backpressure: pipe fills after P accepts, output holds, then drains in order.
                out_ready = 1'b0;
                acc = 0;
                for (int n = 0; n < 6; n++) begin
                    drive(1'b1, SRL, 32'hA000_0000, 5'(acc + 1), 5'(10 + acc));
                    #2;
                    if (!in_ready) break;
                    acc++;
                    sync();
                end
                in_valid = 1'b0;
                check("accepts before full", gi, acc, 32'd2);
                repeat (3) begin
                    sync();
                    #2;
                    check("stall valid", gi, {31'b0, out_valid}, 32'd1);
                    check("stall data", gi, out_data, 32'h5000_0000);
                    check("stall in_ready", gi, {31'b0, in_ready}, 32'd0);
                end
                sync();
                out_ready = 1'b1;
                #2 check("drain tag0", gi, {27'b0, out_tag}, 32'd10);
                sync();
                #2 check("drain tag1", gi, {27'b0, out_tag}, 32'd11);
                check("drain data1", gi, out_data, 32'h2800_0000);
                sync();
                #2 check("drain empty", gi, {31'b0, out_valid}, 32'd0);

                // Flush with two ops in flight and a simultaneous input.
                sync();
                drive(1'b1, SLL, 32'd1, 5'd1, 5'd20);
                sync();
                drive(1'b1, SLL, 32'd1, 5'd2, 5'd21);
                sync();
                drive(1'b1, SLL, 32'd1, 5'd3, 5'd22);
                flush = 1'b1;
                #2 check("flush in_ready", gi, {31'b0, in_ready}, 32'd0);
                sync();
                flush = 1'b0;
                in_valid = 1'b0;
                #2 check("flush killed", gi, {31'b0, out_valid}, 32'd0);
                sync();
                #2 check("flushed input dropped", gi, {31'b0, out_valid}, 32'd0);
                run_one("post flush", SRL, 32'h8000_0000, 5'd4, 5'd23, 32'h0800_0000);

                // Asynchronous reset with a full pipe.
                sync();
                drive(1'b1, SLL, 32'd3, 5'd1, 5'd24);
                sync();
                drive(1'b1, SLL, 32'd3, 5'd2, 5'd25);
                sync();
                drive(1'b1, SLL, 32'd3, 5'd3, 5'd26);
                #1 check("pre-reset valid", gi, {31'b0, out_valid}, 32'd1);
                rst_n = 1'b0;
                #1 check("async reset valid", gi, {31'b0, out_valid}, 32'd0);
                check("async reset data", gi, out_data, 32'd0);
                in_valid = 1'b0;
                sync();
                sync();
                rst_n = 1'b1;
                #2 check("release in_ready", gi, {31'b0, in_ready}, 32'd1);
                check("release valid", gi, {31'b0, out_valid}, 32'd0);
                repeat (3) sync();
                done_cnt++;
            end
        end else begin : g_random
            initial begin
                rst_n = 1'b1;
                flush = 1'b0;
                out_ready = 1'b1;
                drive(1'b0, SLL, 32'd0, 5'd0, 5'd0);
                #1 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                for (int n = 0; n < 1500; n++) begin
                    sync();
                    if (!rst_n) rst_n = 1'b1;
                    drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom,
                          ($urandom_range(0, 7) == 0) ? 5'd0 :
                          ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom), 5'($urandom));
                    out_ready = $urandom_range(0, 3) != 0;
                    flush = $urandom_range(0, 39) == 0;
                    if ($urandom_range(0, 249) == 0) begin
                        #1 rst_n = 1'b0;
                        #1 check("random async reset", gi, {31'b0, out_valid}, 32'd0);
                    end
                end
                sync();
                rst_n = 1'b1;
                in_valid = 1'b0;
                flush = 1'b0;
                out_ready = 1'b1;
                repeat (P + 3) sync();
                done_cnt++;
            end
        end
    end

    initial begin
        for (int c = 0; c < 20000 && done_cnt < 6; c++) @(posedge clk);
        if (done_cnt < 6) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout: %0d of 6 drivers finished, expected 6", done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
